// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM states and flag bit positions shared by the sequential ALU.
package seq_alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_RSB, OP_AND, OP_BIC, OP_OR, OP_XOR,
    OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_MOV, OP_MULU, OP_DIVU, OP_RSV
  } op_e;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned shift-add multiplier / restoring divider, WIDTH steps per op.
// The start cycle already performs the first step so the result is ready after exactly WIDTH edges.
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_done
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] r_lo, r_hi, r_b;
  logic             r_div, r_busy, r_done;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] w_lo_in, w_hi_in, w_b_in, w_lo_nx, w_hi_nx, w_sub;
  logic [WIDTH:0]   w_sum, w_rem;
  logic             w_div_in, w_fit;
  assign w_lo_in  = i_start ? i_a : r_lo;
  assign w_hi_in  = i_start ? '0 : r_hi;
  assign w_b_in   = i_start ? i_b : r_b;
  assign w_div_in = i_start ? i_is_div : r_div;
  assign w_sum    = {1'b0, w_hi_in} + (w_lo_in[0] ? {1'b0, w_b_in} : '0);
  // divide: remainder lives in hi, quotient bits shift into lo as dividend bits leave it
  assign w_rem    = {w_hi_in, w_lo_in[WIDTH-1]};
  assign w_fit    = w_rem >= {1'b0, w_b_in};
  assign w_sub    = w_rem[WIDTH-1:0] - w_b_in;
  assign w_hi_nx  = w_div_in ? (w_fit ? w_sub : w_rem[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign w_lo_nx  = w_div_in ? {w_lo_in[WIDTH-2:0], w_fit} : {w_sum[0], w_lo_in[WIDTH-1:1]};
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_b    <= '0;
      r_div  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_busy) begin
        r_lo   <= w_lo_nx;
        r_hi   <= w_hi_nx;
        r_b    <= w_b_in;
        r_div  <= w_div_in;
        r_cnt  <= i_start ? SHW'(1) : r_cnt + 1'b1;
        r_busy <= i_start || ~&r_cnt;
        r_done <= !i_start && r_busy && &r_cnt;
      end
    end
  end
  assign o_lo   = r_lo;
  assign o_hi   = r_hi;
  assign o_done = r_done;
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result/flags; single-cycle ops plus iterative MULU/DIVU.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_op_sel,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_op0_a_bus,
  input  logic [WIDTH-1:0] i_op1_b_bus,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic [3:0]       o_flag,
  output logic             o_err
);
  localparam int SHW = $clog2(WIDTH);
  state_e           r_state;
  logic             r_in_ready, r_out_valid, r_err, r_div, r_err_pend;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic [3:0]       r_flag;
  op_e              w_op;
  logic [WIDTH-1:0] w_a, w_b, w_x, w_y, w_ror, w_res, w_lo, w_hi;
  logic [WIDTH:0]   w_sum, w_lsl, w_lsr, w_asr;
  logic [SHW-1:0]   w_sh, w_nsh;
  logic             w_ci, w_ovf, w_z0, w_c, w_v, w_start, w_muldiv, w_done;
  logic [3:0]       w_flag, w_mflag;
  assign w_op     = op_e'(i_op_sel);
  assign w_a      = i_op0_a_bus;
  assign w_b      = i_op1_b_bus;
  assign w_muldiv = w_op == OP_MULU || w_op == OP_DIVU;
  assign w_start  = r_state == IDLE && i_in_valid && w_muldiv;
  // ADD/ADC/SUB/RSB share one adder: operands swapped/inverted with carry-in as needed
  assign w_x   = w_op == OP_RSB ? w_b : w_a;
  assign w_y   = w_op == OP_SUB ? ~w_b : w_op == OP_RSB ? ~w_a : w_b;
  assign w_ci  = w_op == OP_ADC ? i_cin : (w_op == OP_SUB || w_op == OP_RSB);
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + (WIDTH+1)'(w_ci);
  assign w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
  assign w_sh  = w_b[SHW-1:0];
  assign w_nsh = ~w_sh + 1'b1;
  assign w_z0  = w_sh == '0;
  // the extra bit on each shifter catches the last bit shifted out
  assign w_lsl = {1'b0, w_a} << w_sh;
  assign w_lsr = {w_a, 1'b0} >> w_sh;
  assign w_asr = $signed({w_a, 1'b0}) >>> w_sh;
  assign w_ror = (w_a >> w_sh) | (w_a << w_nsh);
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_ADC, OP_SUB, OP_RSB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      OP_AND: w_res = w_a & w_b;
      OP_BIC: w_res = w_a & ~w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_LSL: begin
        w_res = w_lsl[WIDTH-1:0];
        w_c   = w_z0 ? i_cin : w_lsl[WIDTH];
      end
      OP_LSR: begin
        w_res = w_lsr[WIDTH:1];
        w_c   = w_z0 ? i_cin : w_lsr[0];
      end
      OP_ASR: begin
        w_res = w_asr[WIDTH:1];
        w_c   = w_z0 ? i_cin : w_asr[0];
      end
      OP_ROR: begin
        w_res = w_ror;
        w_c   = w_z0 ? i_cin : w_ror[WIDTH-1];
      end
      OP_MOV: w_res = w_b;
      default: w_res = '0;
    endcase
    w_flag         = '0;
    w_flag[FLAG_N] = w_res[WIDTH-1];
    w_flag[FLAG_Z] = ~|w_res;
    w_flag[FLAG_C] = w_c;
    w_flag[FLAG_V] = w_v;
    w_mflag         = '0;
    w_mflag[FLAG_N] = w_lo[WIDTH-1];
    w_mflag[FLAG_Z] = ~|w_lo;
    w_mflag[FLAG_C] = !r_div && |w_hi;
  end
  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_is_div(w_op == OP_DIVU),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_lo    (w_lo),
    .o_hi    (w_hi),
    .o_done  (w_done)
  );
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flag      <= '0;
      r_err       <= 1'b0;
      r_div       <= 1'b0;
      r_err_pend  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_in_valid) begin
          r_in_ready <= 1'b0;
          if (w_muldiv) begin
            r_state    <= ITER;
            r_div      <= w_op == OP_DIVU;
            r_err_pend <= w_op == OP_DIVU && w_b == '0;
          end else begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_result_hi <= '0;
            r_flag      <= w_flag;
            r_err       <= 1'b0;
          end
        end
        ITER: if (w_done) begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_lo;
          r_result_hi <= w_hi;
          r_flag      <= w_mflag;
          r_err       <= r_err_pend;
        end
        DONE: if (i_out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_result_hi = r_result_hi;
  assign o_flag      = r_flag;
  assign o_err       = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
  logic        clk, rst, in_valid, in_ready, cin, out_valid, out_ready, err;
  logic [3:0]  op_sel, flag;
  logic [31:0] a_bus, b_bus, result, result_hi;
  int checks, errors;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;
  typedef struct packed {
    logic [3:0]  op;
    logic        cin;
    logic [31:0] a, b, r, h;
    logic [3:0]  f;
    logic        e;
    logic [7:0]  lat;
  } vec_t;
  seq_alu #(.WIDTH(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op_sel(op_sel), .i_cin(cin), .i_op0_a_bus(a_bus), .i_op1_b_bus(b_bus),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
    .o_result_hi(result_hi), .o_flag(flag), .o_err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic ref_model(input logic [3:0] op, input logic ci, input logic [31:0] a, b,
                           output logic [31:0] r, h, output logic [3:0] f, output logic e,
                           output int lat);
    logic [63:0] p;
    longint t;
    logic c, v;
    int d;
    r = '0; h = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    lat = (op == 4'd13 || op == 4'd14) ? 33 : 1;
    d = int'(b[4:0]);
    case (op)
      4'd0, 4'd1: begin
        p = {32'b0, a} + {32'b0, b} + ((op == 4'd1 && ci) ? 64'd1 : 64'd0);
        r = p[31:0]; c = p[32];
        t = longint'($signed(a)) + longint'($signed(b)) + ((op == 4'd1 && ci) ? 1 : 0);
        v = t > MAXI || t < MINI;
      end
      4'd2: begin
        r = a - b; c = a >= b;
        t = longint'($signed(a)) - longint'($signed(b));
        v = t > MAXI || t < MINI;
      end
      4'd3: begin
        r = b - a; c = b >= a;
        t = longint'($signed(b)) - longint'($signed(a));
        v = t > MAXI || t < MINI;
      end
      4'd4: r = a & b;
      4'd5: r = a & ~b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8, 4'd9, 4'd10, 4'd11: begin
        r = a; c = ci;
        for (int i = 0; i < d; i++) begin
          if (op == 4'd8) begin c = r[31]; r = r << 1; end
          else if (op == 4'd9) begin c = r[0]; r = r >> 1; end
          else if (op == 4'd10) begin c = r[0]; r = {r[31], r[31:1]}; end
          else begin c = r[0]; r = {r[0], r[31:1]}; end
        end
      end
      4'd12: r = b;
      4'd13: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0]; h = p[63:32]; c = h != 0;
      end
      4'd14: begin
        if (b == 0) begin r = '1; h = a; e = 1'b1; end
        else begin r = a / b; h = a % b; end
      end
      default: r = '0;
    endcase
    f = {r[31], r == 0, c, v};
  endtask
  // issue one request from a negedge with the DUT idle; returns outputs, latency and in_ready count while busy
  task automatic run_op(input logic [3:0] op, input logic ci, input logic [31:0] a, b,
                        output logic [31:0] r, h, output logic [3:0] f, output logic e,
                        output int lat, output int rdy_hi);
    op_sel = op; cin = ci; a_bus = a; b_bus = b; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1; rdy_hi = 0;
    while (!out_valid && lat < 100) begin
      rdy_hi += int'(in_ready);
      @(posedge clk); @(negedge clk);
      lat++;
    end
    rdy_hi += int'(in_ready);
    r = result; h = result_hi; f = flag; e = err;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask
  function automatic vec_t dvec(int i);
    case (i)
      0:  return {4'd0,  1'b0, 32'h7FFFFFFF, 32'h1,  32'h80000000, 32'h0,    4'b1001, 1'b0, 8'd1};
      1:  return {4'd2,  1'b0, 32'h5,        32'h5,  32'h0,        32'h0,    4'b0110, 1'b0, 8'd1};
      2:  return {4'd3,  1'b0, 32'h1,        32'h0,  32'hFFFFFFFF, 32'h0,    4'b1000, 1'b0, 8'd1};
      3:  return {4'd9,  1'b0, 32'h80000001, 32'h1,  32'h40000000, 32'h0,    4'b0010, 1'b0, 8'd1};
      4:  return {4'd8,  1'b1, 32'h12345678, 32'h20, 32'h12345678, 32'h0,    4'b0010, 1'b0, 8'd1};
      5:  return {4'd11, 1'b0, 32'h1,        32'h1,  32'h80000000, 32'h0,    4'b1010, 1'b0, 8'd1};
      6:  return {4'd13, 1'b0, 32'hFFFFFFFF, 32'h2,  32'hFFFFFFFE, 32'h1,    4'b1010, 1'b0, 8'd33};
      7:  return {4'd14, 1'b0, 32'd100,      32'd7,  32'd14,       32'd2,    4'b0000, 1'b0, 8'd33};
      8:  return {4'd14, 1'b0, 32'h1234,     32'h0,  32'hFFFFFFFF, 32'h1234, 4'b1000, 1'b1, 8'd33};
      9:  return {4'd15, 1'b0, 32'hAAAA,     32'h5555, 32'h0,      32'h0,    4'b0100, 1'b0, 8'd1};
      10: return {4'd10, 1'b0, 32'h80000000, 32'h4,  32'hF8000000, 32'h0,    4'b1000, 1'b0, 8'd1};
      11: return {4'd1,  1'b1, 32'hFFFFFFFF, 32'h0,  32'h0,        32'h0,    4'b0110, 1'b0, 8'd1};
      default: return {4'd5, 1'b0, 32'hFF,   32'h0F, 32'hF0,       32'h0,    4'b0000, 1'b0, 8'd1};
    endcase
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 0 || result_hi !== 0 || flag !== 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b res=%h hi=%h flag=%b err=%b, want 0 1 0 0 0000 0",
               out_valid, in_ready, result, result_hi, flag, err);
    end
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_directed;
    vec_t v;
    logic [31:0] r, h;
    logic [3:0] f;
    logic e;
    int lat, rdy;
    for (int i = 0; i < 13; i++) begin
      v = dvec(i);
      run_op(v.op, v.cin, v.a, v.b, r, h, f, e, lat, rdy);
      checks++;
      if (r !== v.r || h !== v.h) begin
        errors++;
        $display("FAIL dir%0d result: got %h:%h want %h:%h", i, h, r, v.h, v.r);
      end
      checks++;
      if (f !== v.f || e !== v.e) begin
        errors++;
        $display("FAIL dir%0d flags: got %b err=%b want %b err=%b", i, f, e, v.f, v.e);
      end
      checks++;
      if (lat != int'(v.lat) || rdy != 0) begin
        errors++;
        $display("FAIL dir%0d timing: latency %0d ready-while-busy %0d want %0d 0", i, lat, rdy, v.lat);
      end
    end
  endtask
  task automatic test_random;
    logic [3:0] op, f, ef;
    logic ci, e, ee;
    logic [31:0] a, b, r, h, er, eh;
    int lat, rdy, elat;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ci = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ref_model(op, ci, a, b, er, eh, ef, ee, elat);
      run_op(op, ci, a, b, r, h, f, e, lat, rdy);
      checks++;
      if (r !== er || h !== eh || f !== ef || e !== ee || lat != elat || rdy != 0) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h cin=%b: got %h:%h f=%b e=%b lat=%0d rdy=%0d want %h:%h f=%b e=%b lat=%0d",
                 i, op, a, b, ci, h, r, f, e, lat, rdy, eh, er, ef, ee, elat);
      end
    end
  endtask
  task automatic test_hold;
    logic [31:0] a, b, er, eh;
    logic [3:0] ef;
    logic ee;
    int elat;
    a = $urandom; b = $urandom;
    ref_model(4'd4, 1'b0, a, b, er, eh, ef, ee, elat);
    op_sel = 4'd4; a_bus = a; b_bus = b; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    op_sel = 4'd0; a_bus = ~a; b_bus = 32'h1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || result_hi !== 0 || flag !== ef || err !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: valid=%b ready=%b res=%h flag=%b want 1 0 %h %b", i, out_valid, in_ready, result, flag, er, ef);
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask
  task automatic test_abort;
    int seen;
    op_sel = 4'd13; a_bus = 32'hDEADBEEF; b_bus = 32'h3; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: ready=%b valid=%b want 0 0", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reset: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      seen += int'(out_valid);
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_result: valid cycles %0d ready=%b want 0 1", seen, in_ready);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] r, h, er, eh;
    logic [3:0] f, ef;
    logic e, ee;
    int lat, rdy, elat;
    for (int i = 0; i < 4; i++) begin
      ref_model(4'(i * 3), 1'b1, 32'h0F0F1234 + 32'(i), 32'h00000003, er, eh, ef, ee, elat);
      run_op(4'(i * 3), 1'b1, 32'h0F0F1234 + 32'(i), 32'h00000003, r, h, f, e, lat, rdy);
      checks++;
      if (r !== er || h !== eh || f !== ef || e !== ee || lat != elat || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d: got %h:%h f=%b lat=%0d ready=%b valid=%b want %h:%h f=%b lat=%0d 1 0",
                 i, h, r, f, lat, in_ready, out_valid, eh, er, ef, elat);
      end
    end
  endtask
  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sel = '0; cin = 1'b0; a_bus = '0; b_bus = '0;
    test_reset;
    test_directed;
    test_random;
    test_hold;
    test_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU.
- Registers every result and its N/Z/C/V flags, adding ROR, BIC, RSB and ADC to the existing add/logic/shift/move set.
- Adds iterative unsigned multiply and divide that take WIDTH cycles.
- Sits between the operand/register-read stage and writeback; the control unit drives it through a valid/ready pair instead of assuming single-cycle completion.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, minimum 8
SHW, $clog2(WIDTH), shift-distance width (derived; not overridden)

Ports:
CLOCK  in  1  single system clock, rising edge
RESET  in  1  asynchronous, active-high; clears all state
IN_VALID  in  1  operation request
IN_READY  out  1  block can accept a request
OP_SEL  in  4  operation code (see Behaviour)
CIN  in  1  carry input for ADC; C result for zero-distance shifts
OP0_A_BUS  in  WIDTH  operand A
OP1_B_BUS  in  WIDTH  operand B; bits [SHW-1:0] give the shift distance
OUT_VALID  out  1  result/flags valid
OUT_READY  in  1  consumer accepts result
RESULT  out  WIDTH  primary result; quotient for DIVU
RESULT_HI  out  WIDTH  MULU high word, DIVU remainder, else 0
FLAG  out  4  [3]=N, [2]=Z, [1]=C, [0]=V
ERR  out  1  DIVU with B==0

Behaviour:
- Reset: all outputs are 0 except IN_READY=1; state=IDLE. Asserting RESET mid-operation aborts the operation, and no result is produced.
- Clock and reset: one clock, CLOCK; RESET is asynchronous and active-high.
- Opcodes:
  - 0 ADD: A+B
  - 1 ADC: A+B+CIN
  - 2 SUB: A+~B+1
  - 3 RSB: B+~A+1
  - 4 AND
  - 5 BIC: A&~B
  - 6 OR
  - 7 XOR
  - 8 LSL
  - 9 LSR
  - 10 ASR
  - 11 ROR
  - 12 MOV: B
  - 13 MULU
  - 14 DIVU
  - 15 reserved: RESULT=0, FLAG=4'b0100
- FSM states are IDLE, ITER and DONE.
- IDLE:
  - IN_READY=1.
  - A handshake occurs when IN_VALID=1 in IDLE.
  - On handshake, OP_SEL, CIN and both operands are captured.
  - Opcodes 0-12 and 15 compute in the same cycle and go to DONE, giving OUT_VALID on the next edge (latency 1).
  - Opcodes 13 and 14 go to ITER.
- ITER:
  - One shift-add (MULU) or restore-subtract (DIVU) step per cycle, with a WIDTH-cycle counter.
  - After WIDTH steps, go to DONE. OUT_VALID rises WIDTH+1 cycles after the handshake.
  - Inputs are ignored and IN_READY=0.
- DONE:
  - OUT_VALID=1; RESULT, RESULT_HI, FLAG and ERR are held stable until OUT_READY=1.
  - On that edge, go to IDLE and drop OUT_VALID.
  - IN_READY=0 in DONE, so there is no overlap. Sustained throughput is one single-cycle op per 2 cycles.
- Flags:
  - N=RESULT[WIDTH-1]; Z=(RESULT==0) for all ops.
  - C for add/sub/rsb/adc: carry-out of the WIDTH-bit add (SUB: 1 means no borrow).
  - C for shifts: last bit shifted out; distance 0 gives C=CIN and RESULT=A. ROR distance 0 gives C=CIN.
  - C for MULU: (RESULT_HI!=0).
  - C for logic/MOV/DIVU/reserved: 0.
  - V is signed overflow for ADD/ADC/SUB/RSB only; 0 otherwise.
- Shifts:
  - Distance is OP1_B_BUS[SHW-1:0]; upper bits of B are ignored.
  - ASR fills with A[WIDTH-1].
- DIVU with B==0: no special case. The restoring algorithm yields quotient all-ones and remainder=A, with latency unchanged; ERR=1. ERR=0 for all other ops.
- Signed-ness: MULU and DIVU are unsigned only.

Decomposition:
- Package seq_alu_pkg holds:
  - the op_e opcode enum (4 bits);
  - the state_e enum (IDLE/ITER/DONE);
  - the FLAG bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module seq_alu_muldiv is the iterative engine. Its interface:
  - inputs start, is_div, A, B;
  - outputs lo, hi, done (a one-cycle pulse after WIDTH steps);
  - parameterised by WIDTH, with the same CLOCK/RESET.
- The top level holds the FSM, the combinational op unit and the output registers.

Test Plan (WIDTH=32):
1. ADD 0x7FFFFFFF+0x00000001, OUT_READY=1 -> OUT_VALID exactly 1 cycle after handshake; RESULT=0x80000000, FLAG=4'b1001.
2. SUB 5-5 -> RESULT=0, FLAG=4'b0110. RSB A=1,B=0 -> RESULT=0xFFFFFFFF, FLAG=4'b1000.
3. LSR A=0x80000001, B=1 -> RESULT=0x40000000, C=1. LSL with B=0x20 (distance 0), CIN=1 -> RESULT=A, C=1. ROR A=0x1, B=1 -> RESULT=0x80000000, C=1.
4. MULU 0xFFFFFFFF*2 -> OUT_VALID 33 cycles after handshake; RESULT=0xFFFFFFFE, RESULT_HI=0x1, FLAG=4'b1010; IN_READY=0 throughout.
5. DIVU 100/7 -> RESULT=14, RESULT_HI=2, ERR=0. DIVU 0x1234/0 -> RESULT=0xFFFFFFFF, RESULT_HI=0x1234, ERR=1.
6. Hold OUT_READY=0 for 5 cycles after an AND -> outputs stable and IN_READY=0. Then RESET=1 asynchronously at cycle 10 of a MULU -> OUT_VALID=0 and IN_READY=1 immediately, and no result is produced after release.
